// File: rtl/weight_drm_sched_if.sv
// Handshake and DRM-side bundle for the weight DRM scheduler.
// slave = scheduler view, master = environment view.
interface weight_drm_sched_if #(
  parameter int DATA_IN_WIDTH = 324,
  parameter int WR_ADDR_DEPTH = 10,
  parameter int RD_ADDR_DEPTH = 8
);
  logic                       cfg_valid;
  logic                       cfg_ready;
  logic [RD_ADDR_DEPTH-2:0]   cfg_rows_m1;
  logic [7:0]                 cfg_passes_m1;
  logic [DATA_IN_WIDTH-1:0]   s_data;
  logic                       s_valid;
  logic                       s_ready;
  logic [DATA_IN_WIDTH-1:0]   WeightDRM_data_wr;
  logic                       WeightDRM_valid_wr;
  logic [WR_ADDR_DEPTH-1:0]   WeightDRM_addr_wr;
  logic [RD_ADDR_DEPTH-1:0]   WeightDRM_addr_rd;
  logic                       m_ready;
  logic                       m_valid;
  logic                       m_last;
  logic                       m_done;
  logic [1:0]                 bank_full;

  modport slave (
    input  cfg_valid, cfg_rows_m1, cfg_passes_m1,
    input  s_data, s_valid, m_ready,
    output cfg_ready, s_ready,
    output WeightDRM_data_wr, WeightDRM_valid_wr,
    output WeightDRM_addr_wr, WeightDRM_addr_rd,
    output m_valid, m_last, m_done, bank_full
  );

  modport master (
    output cfg_valid, cfg_rows_m1, cfg_passes_m1,
    output s_data, s_valid, m_ready,
    input  cfg_ready, s_ready,
    input  WeightDRM_data_wr, WeightDRM_valid_wr,
    input  WeightDRM_addr_wr, WeightDRM_addr_rd,
    input  m_valid, m_last, m_done, bank_full
  );
endinterface

// File: rtl/weight_drm_sched.sv
// Ping-pong fill / multi-pass replay sequencer for the weight DRM.
// Write side fills one bank while the read side replays the other.
module weight_drm_sched #(
  parameter int DATA_IN_WIDTH = 324,
  parameter int WR_ADDR_DEPTH = 10,
  parameter int RD_ADDR_DEPTH = 8,
  parameter int RD_LATENCY    = 1
) (
  input logic               clk,
  input logic               rstn,
  weight_drm_sched_if.slave bus
);

  localparam int WCW = WR_ADDR_DEPTH - 1;
  localparam int RW  = RD_ADDR_DEPTH - 1;

  typedef enum logic { W_IDLE, W_FILL } wst_t;
  typedef enum logic { R_IDLE, R_RUN } rst_t;

  wst_t               wst_q, wst_d;
  rst_t               rst_q, rst_d;
  logic               wbank_q, wbank_d;
  logic               rbank_q, rbank_d;
  logic [WCW-1:0]     wcnt_q, wcnt_d;
  logic [RW-1:0]      row_q, row_d;
  logic [7:0]         pass_q, pass_d;
  logic [RW-1:0]      rows_q [2];
  logic [RW-1:0]      rows_d [2];
  logic [7:0]         passes_q [2];
  logic [7:0]         passes_d [2];
  logic [1:0]         full_q, full_d;
  logic [RD_ADDR_DEPTH-1:0] addr_rd_q, addr_rd_d;
  logic               issue_q, issue_d;
  logic               last_q, last_d;
  logic               done_q, done_d;
  logic [2:0]         pipe_q [RD_LATENCY];
  logic [2:0]         pipe_d [RD_LATENCY];

  logic cfg_fire, wr_fire, wr_last;
  logic rd_issue, row_last, pass_last, rd_end;

  assign bus.cfg_ready = (wst_q == W_IDLE)
                       & ~full_q[wbank_q];
  assign bus.s_ready   = (wst_q == W_FILL);
  assign cfg_fire = bus.cfg_valid & bus.cfg_ready;
  assign wr_fire  = bus.s_valid & bus.s_ready;
  assign wr_last  = wcnt_q == {rows_q[wbank_q], 2'b11};

  assign bus.WeightDRM_data_wr  = bus.s_data;
  assign bus.WeightDRM_valid_wr = wr_fire;
  assign bus.WeightDRM_addr_wr  = {wbank_q, wcnt_q};
  assign bus.WeightDRM_addr_rd  = addr_rd_q;
  assign bus.bank_full          = full_q;

  assign rd_issue  = (rst_q == R_RUN) & bus.m_ready;
  assign row_last  = row_q == rows_q[rbank_q];
  assign pass_last = pass_q == passes_q[rbank_q];
  assign rd_end    = rd_issue & row_last & pass_last;

  assign bus.m_valid = pipe_q[RD_LATENCY-1][0];
  assign bus.m_last  = pipe_q[RD_LATENCY-1][1];
  assign bus.m_done  = pipe_q[RD_LATENCY-1][2];

  always_comb begin
    wst_d    = wst_q;
    rst_d    = rst_q;
    wbank_d  = wbank_q;
    rbank_d  = rbank_q;
    wcnt_d   = wcnt_q;
    row_d    = row_q;
    pass_d   = pass_q;
    rows_d   = rows_q;
    passes_d = passes_q;
    full_d   = full_q;

    unique case (wst_q)
      W_IDLE: begin
        if (cfg_fire) begin
          rows_d[wbank_q]   = bus.cfg_rows_m1;
          passes_d[wbank_q] = bus.cfg_passes_m1;
          wcnt_d            = '0;
          wst_d             = W_FILL;
        end
      end
      W_FILL: begin
        if (wr_fire) begin
          wcnt_d = wcnt_q + WCW'(1);
          if (wr_last) begin
            full_d[wbank_q] = 1'b1;
            wbank_d         = ~wbank_q;
            wcnt_d          = '0;
            wst_d           = W_IDLE;
          end
        end
      end
    endcase

    unique case (rst_q)
      R_IDLE: begin
        if (full_q[rbank_q]) begin
          row_d  = '0;
          pass_d = '0;
          rst_d  = R_RUN;
        end
      end
      R_RUN: begin
        if (rd_end) begin
          full_d[rbank_q] = 1'b0;
          rbank_d         = ~rbank_q;
          row_d           = '0;
          pass_d          = '0;
          // chain straight into a bank that is already loaded
          rst_d = full_q[~rbank_q] ? R_RUN : R_IDLE;
        end else if (rd_issue) begin
          if (row_last) begin
            row_d  = '0;
            pass_d = pass_q + 8'd1;
          end else begin
            row_d = row_q + RW'(1);
          end
        end
      end
    endcase
  end

  always_comb begin
    issue_d   = rd_issue;
    last_d    = rd_issue & row_last;
    done_d    = rd_end;
    addr_rd_d = rd_issue ? {rbank_q, row_q}
                         : addr_rd_q;
  end

  always_comb begin
    pipe_d[0] = {done_q, last_q, issue_q};
    for (int i = 1; i < RD_LATENCY; i++)
      pipe_d[i] = pipe_q[i-1];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wst_q     <= W_IDLE;
      rst_q     <= R_IDLE;
      wbank_q   <= 1'b0;
      rbank_q   <= 1'b0;
      wcnt_q    <= '0;
      row_q     <= '0;
      pass_q    <= '0;
      rows_q    <= '{default: '0};
      passes_q  <= '{default: '0};
      full_q    <= 2'b00;
      addr_rd_q <= '0;
      issue_q   <= 1'b0;
      last_q    <= 1'b0;
      done_q    <= 1'b0;
      pipe_q    <= '{default: '0};
    end else begin
      wst_q     <= wst_d;
      rst_q     <= rst_d;
      wbank_q   <= wbank_d;
      rbank_q   <= rbank_d;
      wcnt_q    <= wcnt_d;
      row_q     <= row_d;
      pass_q    <= pass_d;
      rows_q    <= rows_d;
      passes_q  <= passes_d;
      full_q    <= full_d;
      addr_rd_q <= addr_rd_d;
      issue_q   <= issue_d;
      last_q    <= last_d;
      done_q    <= done_d;
      pipe_q    <= pipe_d;
    end
  end

endmodule

// File: tb/tb_weight_drm_sched.sv
// Directed bench for weight_drm_sched with a queue-based
// model of the expected write and read streams.
module tb_weight_drm_sched;

  localparam int DW = 324;
  localparam int WA = 10;
  localparam int RA = 8;
  localparam int RL = 1;
  localparam int WBANK = 2 ** (WA - 1);
  localparam int RBANK = 2 ** (RA - 1);

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  weight_drm_sched_if #(
    .DATA_IN_WIDTH(DW),
    .WR_ADDR_DEPTH(WA),
    .RD_ADDR_DEPTH(RA)
  ) bus ();

  weight_drm_sched #(
    .DATA_IN_WIDTH(DW),
    .WR_ADDR_DEPTH(WA),
    .RD_ADDR_DEPTH(RA),
    .RD_LATENCY(RL)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .bus(bus)
  );

  typedef struct {
    int addr;
    bit last;
    bit done;
  } rd_t;

  int  nvec = 0;
  int  nerr = 0;
  rd_t rdq [$];
  rd_t e;
  int  mw = 0;
  int  wbase = 0;
  int  widx = 0;
  int  nlast = 0;
  int  ndone = 0;
  logic [RA-1:0] prev_ard = '0;

  task automatic chk(string nm,
                     logic [63:0] act,
                     logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d want %0d @%0t",
               nm, act, exp, $time);
    end
  endtask

  // expected replay order of one layer
  task automatic push_layer(int rows, int passes, int bank);
    rd_t x;
    for (int p = 0; p < passes; p++)
      for (int r = 0; r < rows; r++) begin
        x.addr = bank * RBANK + r;
        x.last = (r == rows - 1);
        x.done = (r == rows - 1) && (p == passes - 1);
        rdq.push_back(x);
      end
  endtask

  always @(negedge clk) begin
    if (rstn) begin
      if (bus.cfg_valid && bus.cfg_ready) begin
        push_layer(int'(bus.cfg_rows_m1) + 1,
                   int'(bus.cfg_passes_m1) + 1, mw);
        wbase = mw * WBANK;
        widx  = 0;
        mw    = 1 - mw;
      end
      chk("valid_wr", bus.WeightDRM_valid_wr,
          bus.s_valid && bus.s_ready);
      if (bus.WeightDRM_valid_wr) begin
        chk("addr_wr", bus.WeightDRM_addr_wr, wbase + widx);
        chk("data_wr", bus.WeightDRM_data_wr === bus.s_data, 1);
        widx++;
      end
      if (bus.m_valid) begin
        if (rdq.size() == 0) begin
          chk("m_valid_extra", bus.m_valid, 0);
        end else begin
          e = rdq.pop_front();
          chk("addr_rd", prev_ard, e.addr);
          chk("m_last", bus.m_last, e.last);
          chk("m_done", bus.m_done, e.done);
        end
        if (bus.m_last) nlast++;
        if (bus.m_done) ndone++;
      end else begin
        chk("idle_flags", {bus.m_last, bus.m_done}, 0);
      end
    end
    prev_ard = bus.WeightDRM_addr_rd;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset();
    chk("rst_cfg_ready", bus.cfg_ready, 1);
    chk("rst_s_ready", bus.s_ready, 0);
    chk("rst_valid_wr", bus.WeightDRM_valid_wr, 0);
    chk("rst_addr_wr", bus.WeightDRM_addr_wr, 0);
    chk("rst_addr_rd", bus.WeightDRM_addr_rd, 0);
    chk("rst_m_valid", bus.m_valid, 0);
    chk("rst_m_last", bus.m_last, 0);
    chk("rst_m_done", bus.m_done, 0);
    chk("rst_bank_full", bus.bank_full, 0);
  endtask

  task automatic model_clear();
    rdq.delete();
    mw    = 0;
    wbase = 0;
    widx  = 0;
  endtask

  task automatic quick_reset();
    rstn = 1'b0;
    model_clear();
    #1 chk_reset();
    @(negedge clk);
    #1 rstn = 1'b1;
    tick();
  endtask

  task automatic do_cfg(int rm1, int pm1);
    bit ok = 0;
    bus.cfg_valid     = 1'b1;
    bus.cfg_rows_m1   = 7'(rm1);
    bus.cfg_passes_m1 = 8'(pm1);
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge clk);
      ok = bus.cfg_ready;
    end
    if (!ok) chk("cfg_timeout", bus.cfg_ready, 1);
    tick();
    bus.cfg_valid     = 1'b0;
    bus.cfg_rows_m1   = 7'($urandom);
    bus.cfg_passes_m1 = 8'($urandom);
    chk("s_ready_after_cfg", bus.s_ready, 1);
  endtask

  task automatic send(int n, int gap, int first_exp);
    logic [351:0] tmp;
    bit ok;
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < 11; k++) tmp[k*32 +: 32] = $urandom;
      bus.s_data  = tmp[DW-1:0];
      bus.s_valid = 1'b1;
      ok = 0;
      for (int j = 0; j < 100 && !ok; j++) begin
        @(negedge clk);
        ok = bus.s_ready;
      end
      if (!ok) chk("s_ready_timeout", bus.s_ready, 1);
      if (i == 0 && first_exp >= 0)
        chk("first_addr_wr", bus.WeightDRM_addr_wr, first_exp);
      tick();
      if (gap > 0 && i < n - 1) begin
        bus.s_valid = 1'b0;
        for (int g = 0; g < gap; g++) begin
          @(negedge clk);
          chk("gap_valid_wr", bus.WeightDRM_valid_wr, 0);
          chk("gap_addr_wr", bus.WeightDRM_addr_wr, wbase + widx);
          tick();
        end
      end
    end
    bus.s_valid = 1'b0;
  endtask

  task automatic drain();
    bit ok = 0;
    bus.m_ready = 1'b1;
    for (int i = 0; i < 5000 && !ok; i++) begin
      @(negedge clk);
      ok = (rdq.size() == 0);
    end
    if (!ok) chk("drain_timeout", rdq.size(), 0);
    repeat (3) tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  initial begin
    int nl0, nd0;
    logic [RA-1:0] a;
    bit ok;
    bus.cfg_valid     = 1'b0;
    bus.cfg_rows_m1   = '0;
    bus.cfg_passes_m1 = '0;
    bus.s_data        = '0;
    bus.s_valid       = 1'b0;
    bus.m_ready       = 1'b1;
    #1 chk_reset();
    #22 rstn = 1'b1;
    tick();

    // single pass, 4 rows
    nl0 = nlast; nd0 = ndone;
    do_cfg(3, 0);
    send(16, 0, 0);
    chk("t1_bank_full", bus.bank_full, 2'b01);
    drain();
    chk("t1_bank_free", bus.bank_full, 2'b00);
    chk("t1_nlast", nlast - nl0, 1);
    chk("t1_ndone", ndone - nd0, 1);

    // 2 rows x 3 passes
    quick_reset();
    nl0 = nlast; nd0 = ndone;
    do_cfg(1, 2);
    send(8, 0, 0);
    drain();
    chk("t2_nlast", nlast - nl0, 3);
    chk("t2_ndone", ndone - nd0, 1);

    // ping-pong overlap
    quick_reset();
    do_cfg(3, 7);
    send(16, 0, 0);
    do_cfg(1, 0);
    chk("pp_bank0_busy", bus.bank_full, 2'b01);
    send(8, 0, WBANK);
    ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      ok = bus.m_valid && bus.m_done;
    end
    chk("pp_done_seen", ok, 1);
    chk("pp_switch_addr", bus.WeightDRM_addr_rd, RBANK);
    @(negedge clk);
    chk("pp_no_gap", bus.m_valid, 1);
    drain();

    // read backpressure, m_ready 1/0
    bus.m_ready = 1'b0;
    do_cfg(2, 1);
    send(12, 0, 0);
    repeat (30) begin
      tick();
      bus.m_ready = 1'b0;
      @(negedge clk);
      a = bus.WeightDRM_addr_rd;
      tick();
      chk("hold_addr_rd", bus.WeightDRM_addr_rd, a);
      bus.m_ready = 1'b1;
    end
    drain();

    // write gaps
    do_cfg(1, 0);
    send(8, 2, WBANK);
    drain();

    // both banks full
    bus.m_ready = 1'b0;
    nd0 = ndone;
    do_cfg(0, 0);
    send(4, 0, 0);
    do_cfg(0, 1);
    send(4, 0, WBANK);
    repeat (3) begin
      @(negedge clk);
      chk("full_cfg_ready", bus.cfg_ready, 0);
    end
    chk("full_bank_full", bus.bank_full, 2'b11);
    tick();
    bus.m_ready = 1'b1;
    ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      ok = bus.cfg_ready;
    end
    chk("full_cfg_reopen", ok, 1);
    chk("full_bank0_freed", bus.bank_full, 2'b10);
    tick();
    drain();
    chk("full_ndone", ndone - nd0, 2);

    // reset in the middle of a fill
    bus.m_ready = 1'b0;
    do_cfg(0, 0);
    send(4, 0, 0);
    do_cfg(3, 0);
    send(5, 0, WBANK);
    chk("pre_rst_addr_wr", bus.WeightDRM_addr_wr, WBANK + 5);
    bus.s_valid = 1'b1;
    #2 rstn = 1'b0;
    model_clear();
    #1 chk_reset();
    @(negedge clk);
    #1 rstn = 1'b1;
    bus.s_valid = 1'b0;
    tick();
    bus.m_ready = 1'b1;
    do_cfg(0, 0);
    send(4, 0, 0);
    drain();
    chk("end_bank_full", bus.bank_full, 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
